// File: rtl/note_scheduler.sv
// Monophonic note-priority scheduler: tracks held notes in a last-note-priority stack
// and drives a note/gate/amplitude envelope to the synth voice.
module note_scheduler #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned ATTACK_DIV  = 4800,
  parameter int unsigned RELEASE_DIV = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] spi_word,
  output logic [6:0]  note,
  output logic        gate,
  output logic [9:0]  amp,
  output logic        active,
  output logic        busy
);

  localparam int unsigned IdxW   = $clog2(STACK_DEPTH);
  localparam int unsigned CntW   = $clog2(STACK_DEPTH + 1);
  localparam int unsigned MaxDiv = (ATTACK_DIV > RELEASE_DIV) ? ATTACK_DIV : RELEASE_DIV;
  localparam int unsigned DivW   = (MaxDiv > 1) ? $clog2(MaxDiv) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StApply, StOut} state_e;
  typedef enum logic [1:0] {EnvIdle, EnvAttack, EnvHold, EnvRelease} env_e;

  state_e            state_q, state_d;
  env_e              env_q, env_d;
  logic [15:0]       spi_q;
  logic              pend_q, pend_d;
  logic [15:0]       pend_word_q, pend_word_d;
  logic              cmd_on_q, cmd_on_d;
  logic              cmd_all_q, cmd_all_d;
  logic [6:0]        cmd_note_q, cmd_note_d;
  logic [6:0]        cmd_vel_q, cmd_vel_d;
  logic [IdxW-1:0]   scan_idx_q, scan_idx_d;
  logic              found_q, found_d;
  logic [IdxW-1:0]   found_idx_q, found_idx_d;
  logic [6:0]        stack_q [STACK_DEPTH];
  logic [6:0]        stack_n [STACK_DEPTH];
  logic [CntW-1:0]   count_q, count_n;
  logic [6:0]        note_q, top_n;
  logic              gate_q, rel_q;
  logic [9:0]        target_q;
  logic [9:0]        amp_q, amp_d;
  logic [DivW-1:0]   div_q, div_d;

  logic              cmd_det, slot_hit, scan_last;
  logic              remove_en, push_en;
  logic [IdxW-1:0]   remove_idx;

  assign cmd_det   = (spi_word != spi_q);
  assign slot_hit  = (CntW'(scan_idx_q) < count_q) && (stack_q[scan_idx_q] == cmd_note_q);
  assign scan_last = (scan_idx_q == IdxW'(STACK_DEPTH - 1));

  // Control FSM: latch latest command, scan the stack one slot per cycle, then apply.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    cmd_on_d    = cmd_on_q;
    cmd_all_d   = cmd_all_q;
    cmd_note_d  = cmd_note_q;
    cmd_vel_d   = cmd_vel_q;
    scan_idx_d  = scan_idx_q;
    found_d     = found_q;
    found_idx_d = found_idx_q;
    if (cmd_det) begin
      pend_d      = 1'b1;
      pend_word_d = spi_word;
    end
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          state_d     = StScan;
          cmd_all_d   = (pend_word_q == 16'h0000);
          cmd_on_d    = pend_word_q[15] && (pend_word_q[6:0] != 7'd0);
          cmd_note_d  = pend_word_q[14:8];
          cmd_vel_d   = pend_word_q[6:0];
          scan_idx_d  = '0;
          found_d     = 1'b0;
          found_idx_d = '0;
          if (!cmd_det) pend_d = 1'b0;
        end
      end
      StScan: begin
        if (slot_hit) begin
          found_d     = 1'b1;
          found_idx_d = scan_idx_q;
        end
        if (scan_last) state_d = StApply;
        else           scan_idx_d = scan_idx_q + 1'b1;
      end
      StApply: state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Stack update: optional removal with compaction, then optional push on top.
  always_comb begin
    remove_en  = 1'b0;
    remove_idx = found_idx_q;
    push_en    = 1'b0;
    if (cmd_on_q) begin
      push_en = 1'b1;
      if (found_q) begin
        remove_en = 1'b1;
      end else if (count_q == CntW'(STACK_DEPTH)) begin
        remove_en  = 1'b1;
        remove_idx = '0;
      end
    end else if (found_q) begin
      remove_en = 1'b1;
    end
    stack_n = stack_q;
    count_n = count_q;
    if (remove_en) begin
      for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) begin
        if (IdxW'(i) >= remove_idx) stack_n[i] = stack_q[i + 1];
      end
      count_n = count_q - 1'b1;
    end
    if (push_en) begin
      stack_n[count_n[IdxW-1:0]] = cmd_note_q;
      count_n = count_n + 1'b1;
    end
    if (cmd_all_q) count_n = '0;
    top_n = (count_n != '0) ? stack_n[IdxW'(count_n - CntW'(1))] : note_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      spi_q       <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      cmd_on_q    <= 1'b0;
      cmd_all_q   <= 1'b0;
      cmd_note_q  <= '0;
      cmd_vel_q   <= '0;
      scan_idx_q  <= '0;
      found_q     <= 1'b0;
      found_idx_q <= '0;
      count_q     <= '0;
      note_q      <= '0;
      gate_q      <= 1'b0;
      rel_q       <= 1'b0;
      target_q    <= '0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      spi_q       <= spi_word;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      cmd_on_q    <= cmd_on_d;
      cmd_all_q   <= cmd_all_d;
      cmd_note_q  <= cmd_note_d;
      cmd_vel_q   <= cmd_vel_d;
      scan_idx_q  <= scan_idx_d;
      found_q     <= found_d;
      found_idx_q <= found_idx_d;
      gate_q      <= 1'b0;
      rel_q       <= 1'b0;
      // Registered at the end of APPLY so gate/note/target are all visible during OUT.
      if (state_q == StApply) begin
        stack_q <= stack_n;
        count_q <= count_n;
        note_q  <= top_n;
        gate_q  <= cmd_on_q;
        rel_q   <= (count_q != '0) && (count_n == '0);
        if (cmd_on_q) target_q <= {cmd_vel_q, 3'b111};
      end
    end
  end

  // Envelope: a gate pulse always (re)starts ATTACK from the current amplitude.
  always_comb begin
    env_d = env_q;
    amp_d = amp_q;
    div_d = div_q;
    unique case (env_q)
      EnvIdle: ;
      EnvAttack: begin
        if (amp_q == target_q) begin
          env_d = EnvHold;
        end else if (div_q == DivW'(ATTACK_DIV - 1)) begin
          div_d = '0;
          amp_d = (amp_q < target_q) ? amp_q + 10'd1 : amp_q - 10'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      EnvHold: ;
      EnvRelease: begin
        if (amp_q == 10'd0) begin
          env_d = EnvIdle;
        end else if (div_q == DivW'(RELEASE_DIV - 1)) begin
          div_d = '0;
          amp_d = amp_q - 10'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: env_d = EnvIdle;
    endcase
    if (gate_q)     env_d = EnvAttack;
    else if (rel_q) env_d = EnvRelease;
    if ((env_d != env_q) || gate_q) div_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_q <= EnvIdle;
      amp_q <= '0;
      div_q <= '0;
    end else begin
      env_q <= env_d;
      amp_q <= amp_d;
      div_q <= div_d;
    end
  end

  assign note   = note_q;
  assign gate   = gate_q;
  assign amp    = amp_q;
  assign active = (count_q != '0);
  assign busy   = (state_q != StIdle);

endmodule
